vga_sync_rx: RTL and testbench
==============================

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameter LINE_LEN, default 800, meaning expected pixel strobes between successive hsync assertions.
REQ-002 Parameter FRAME_LEN, default 525, meaning expected hsync assertions between successive vsync assertions.
REQ-003 Parameter H_ACT_OFS, default 144, meaning strobes from hsync assertion to first active pixel; H_ACT, default 640, active width.
REQ-004 Parameter V_ACT_OFS, default 35, meaning lines from vsync assertion to first active line; V_ACT, default 480, active height.
REQ-005 Parameter LOCK_LINES, default 4, meaning consecutive good lines required before waiting for vsync.
REQ-006 i_clk  input  1  base clock; single clock domain.
REQ-007 i_rst  input  1  reset, synchronous, active-high.
REQ-008 i_pix_stb  input  1  pixel strobe; all sampling and counting occur only on cycles with i_pix_stb=1.
REQ-009 i_hs, i_vs  input  1 each  horizontal/vertical sync, active-low.
REQ-010 o_x  output  10  recovered pixel x; o_y  output  9  recovered pixel y.
REQ-011 o_active  output  1  high while the recovered position is inside the active area and o_locked=1.
REQ-012 o_locked  output  1  high in LOCKED state only.
REQ-013 o_frame_start  output  1  one-i_clk-cycle pulse on the strobe a vsync edge is detected while locked.
REQ-014 o_line_len  output  10  strobe count of the most recently completed line, saturating at 1023.

Function
REQ-015 hs edge = strobe where i_hs=0 and previously sampled i_hs=1; vs edge defined likewise on i_vs.
REQ-016 h_cnt (10 bit): cleared to 0 on hs edge, else +1 per strobe, saturating at 1023.
REQ-017 Line good = hs edge with h_cnt == LINE_LEN-1 before clearing; on every hs edge o_line_len <= min(h_cnt+1, 1023).
REQ-018 v_cnt (10 bit): vs edge clears to 0 and arms skip flag; next hs edge clears skip flag without incrementing; other hs edges increment v_cnt, saturating at 1023.
REQ-019 hs edge and vs edge on same strobe: v_cnt <= 0, skip flag clear.
REQ-020 States SEARCH, MEASURE, WAIT_VS, LOCKED; good-line counter gl_cnt.
REQ-021 SEARCH: first hs edge -> MEASURE, gl_cnt <= 0.
REQ-022 MEASURE: good line increments gl_cnt; gl_cnt reaching LOCK_LINES -> WAIT_VS; bad line -> gl_cnt <= 0, stay.
REQ-023 WAIT_VS: vs edge -> LOCKED; bad line -> MEASURE, gl_cnt <= 0.
REQ-024 LOCKED: bad line -> SEARCH on the same strobe; no hs edge for LINE_LEN+16 strobes (h_cnt reaching LINE_LEN+15) -> SEARCH.
REQ-025 o_x = h_cnt-H_ACT_OFS when H_ACT_OFS <= h_cnt < H_ACT_OFS+H_ACT and locked, else 0.
REQ-026 o_y = v_cnt-V_ACT_OFS when V_ACT_OFS <= v_cnt < V_ACT_OFS+V_ACT and locked, else 0.
REQ-027 o_active = locked AND both ranges of REQ-025/026 satisfied; o_x, o_y, o_active combinational from registered counters.
REQ-028 Outputs change only on strobe cycles except o_frame_start, which lasts exactly one i_clk cycle.

Reset
REQ-029 i_rst=1 at a clock edge: state SEARCH, h_cnt=0, v_cnt=0, gl_cnt=0, skip flag=0, sampled i_hs=i_vs=1, o_line_len=0, regardless of i_pix_stb.
REQ-030 During/after reset: o_locked=0, o_active=0, o_x=0, o_y=0, o_frame_start=0; reset mid-frame discards lock.

Configuration
REQ-031 Macro VGA_SYNC_RX_FRAME_CHECK_EN defined: in LOCKED, vs edge with v_cnt != FRAME_LEN-1 -> SEARCH, no o_frame_start pulse.
REQ-032 Macro undefined: vs edges in LOCKED never affect state; frame length unchecked.

Verification
REQ-033 Feed 640x480 generator output (800-strobe lines, 525 lines), i_pix_stb every 4th clock -> o_locked=1 at first vsync after 4 good lines; o_active pixel count per frame = 307200.
REQ-034 Locked, hsync at generator h=16 -> o_x=0 at generator h=160, o_x=639 at h=799; o_y=0 on line 0, 479 on line 479.
REQ-035 Locked, one line shortened to 790 strobes -> o_locked falls on that hs edge, o_line_len=790; relocks after 4 good lines plus vsync.
REQ-036 Locked, hsync held high 900 strobes -> o_locked=0 at h_cnt=815.
REQ-037 i_rst pulsed mid-frame while locked -> next cycle o_locked=0, o_x=0, o_y=0, o_line_len=0.
REQ-038 FRAME_CHECK_EN defined, frame of 524 lines -> o_locked drops at vsync, no o_frame_start; undefined -> lock held, o_frame_start pulses.

Source files
------------

// File: rtl/vga_sync_rx.sv
// ---------------------------------------------------------------------------
// vga_sync_rx
//
// Recovers pixel coordinates from a VGA-style hsync/vsync pair. Horizontal
// and vertical counters run on pixel strobes. A small FSM locks once it has
// seen LOCK_LINES consecutive lines of the expected length followed by a
// vsync. It drops lock on any malformed line or on a missing hsync.
//
// Optional build macro:
//   VGA_SYNC_RX_FRAME_CHECK_EN  - while locked, a vsync that ends a frame whose
//                                 line count is not FRAME_LEN drops lock and
//                                 suppresses o_frame_start.
//
// Ports:
//   i_clk          base clock (single domain)
//   i_rst          synchronous active-high reset
//   i_pix_stb      pixel strobe; all sampling and counting is qualified by it
//   i_hs, i_vs     horizontal / vertical sync, active-low
//   o_x [9:0]      recovered x inside the active area, else 0
//   o_y [8:0]      recovered y inside the active area, else 0
//   o_active       locked and inside the active area
//   o_locked       FSM is in LOCKED
//   o_frame_start  single-cycle pulse on a vsync edge seen while locked
//   o_line_len     strobe count of the last completed line (saturates 1023)
// ---------------------------------------------------------------------------
module vga_sync_rx #(
   parameter int LINE_LEN   = 800,
   parameter int FRAME_LEN  = 525,
   parameter int H_ACT_OFS  = 144,
   parameter int H_ACT      = 640,
   parameter int V_ACT_OFS  = 35,
   parameter int V_ACT      = 480,
   parameter int LOCK_LINES = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_pix_stb,
   input  logic       i_hs,
   input  logic       i_vs,
   output logic [9:0] o_x,
   output logic [8:0] o_y,
   output logic       o_active,
   output logic       o_locked,
   output logic       o_frame_start,
   output logic [9:0] o_line_len
);

   localparam logic [9:0] CNT_MAX    = 10'd1023;
   localparam logic [9:0] LINE_LAST  = 10'(LINE_LEN - 1);
   localparam logic [9:0] FRAME_LAST = 10'(FRAME_LEN - 1);
   // h_cnt value whose increment would reach LINE_LEN+15, i.e. the
   // (LINE_LEN+16)th strobe without an hsync edge.
   localparam logic [9:0] H_TMO_PRE  = 10'(LINE_LEN + 14);
   localparam logic [9:0] H_BEG      = 10'(H_ACT_OFS);
   localparam logic [9:0] H_END      = 10'(H_ACT_OFS + H_ACT);
   localparam logic [9:0] V_BEG      = 10'(V_ACT_OFS);
   localparam logic [9:0] V_END      = 10'(V_ACT_OFS + V_ACT);

   localparam int              GL_W    = $clog2(LOCK_LINES + 1);
   localparam logic [GL_W-1:0] GL_LAST = GL_W'(LOCK_LINES - 1);

`ifdef VGA_SYNC_RX_FRAME_CHECK_EN
   localparam bit FRAME_CHECK = 1'b1;
`else
   localparam bit FRAME_CHECK = 1'b0;
`endif

   typedef enum logic [1:0] {
      SEARCH,
      MEASURE,
      WAIT_VS,
      LOCKED
   } state_t;

   state_t          state, state_nxt;
   logic [GL_W-1:0] gl_cnt, gl_nxt;

   logic       hs_q, vs_q;
   logic [9:0] h_cnt, v_cnt;
   logic       skip;
   logic [9:0] line_len;

   logic hs_edge, vs_edge;
   logic line_good, line_bad;
   logic h_tmo, frame_bad;
   logic fs;
   logic locked, h_in, v_in;

   // ------------------------------------------------------------------
   // Edge detection and line classification
   // ------------------------------------------------------------------
   assign hs_edge   = i_pix_stb & ~i_hs & hs_q;
   assign vs_edge   = i_pix_stb & ~i_vs & vs_q;
   assign line_good = hs_edge & (h_cnt == LINE_LAST);
   assign line_bad  = hs_edge & (h_cnt != LINE_LAST);

   // Fires on the strobe that would move h_cnt onto LINE_LEN+15, so the
   // state leaves LOCKED together with h_cnt reaching that value.
   assign h_tmo     = i_pix_stb & ~hs_edge & (h_cnt == H_TMO_PRE);

   // v_cnt still holds the index of the last line of the ending frame.
   assign frame_bad = FRAME_CHECK & vs_edge & (v_cnt != FRAME_LAST);

   // ------------------------------------------------------------------
   // Sync sampling and position counters
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hs_q     <= 1'b1;
         vs_q     <= 1'b1;
         h_cnt    <= '0;
         v_cnt    <= '0;
         skip     <= 1'b0;
         line_len <= '0;
      end else if (i_pix_stb) begin
         hs_q <= i_hs;
         vs_q <= i_vs;

         if (hs_edge) begin
            h_cnt    <= '0;
            line_len <= (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 10'd1;
         end else if (h_cnt != CNT_MAX) begin
            h_cnt <= h_cnt + 10'd1;
         end

         // A vsync that lands mid-line leaves v_cnt at 0 for the rest of
         // that line and the next one; skip stops the next hsync from
         // counting it twice. Coincident edges need no skip.
         if (vs_edge) begin
            v_cnt <= '0;
            skip  <= ~hs_edge;
         end else if (hs_edge) begin
            if (skip)
               skip <= 1'b0;
            else if (v_cnt != CNT_MAX)
               v_cnt <= v_cnt + 10'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Lock FSM
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= SEARCH;
         gl_cnt <= '0;
      end else begin
         state  <= state_nxt;
         gl_cnt <= gl_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gl_nxt    = gl_cnt;
      fs        = 1'b0;
      unique case (state)
         SEARCH: begin
            if (hs_edge) begin
               state_nxt = MEASURE;
               gl_nxt    = '0;
            end
         end
         MEASURE: begin
            if (line_good) begin
               gl_nxt = gl_cnt + GL_W'(1);
               if (gl_cnt == GL_LAST)
                  state_nxt = WAIT_VS;
            end else if (line_bad) begin
               gl_nxt = '0;
            end
         end
         WAIT_VS: begin
            // A bad line outranks a coincident vsync.
            if (line_bad) begin
               state_nxt = MEASURE;
               gl_nxt    = '0;
            end else if (vs_edge) begin
               state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            if (line_bad || h_tmo || frame_bad)
               state_nxt = SEARCH;
            else if (vs_edge)
               fs = 1'b1;
         end
         default: begin
            state_nxt = SEARCH;
            gl_nxt    = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign locked = (state == LOCKED);
   assign h_in   = (h_cnt >= H_BEG) && (h_cnt < H_END);
   assign v_in   = (v_cnt >= V_BEG) && (v_cnt < V_END);

   assign o_locked      = locked;
   assign o_active      = locked & h_in & v_in;
   assign o_x           = (locked && h_in) ? (h_cnt - H_BEG) : '0;
   assign o_y           = (locked && v_in) ? 9'(v_cnt - V_BEG) : '0;
   // fs is decoded from the live strobe; keep it quiet while reset is held.
   assign o_frame_start = fs & ~i_rst;
   assign o_line_len    = line_len;

endmodule

// File: tb/tb_vga_sync_rx.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_rx
//
// Scoreboard bench for vga_sync_rx on a scaled-down raster (40-strobe lines,
// 20-line frames, 24x12 active area at offset 8/3) with a strobe every 4th
// clock. The stimulus process pushes expected events (lock changes, frame
// starts, position probes) into a queue; the monitor pops and compares
// whenever the DUT shows the corresponding event.
// ---------------------------------------------------------------------------
module tb_vga_sync_rx;

   localparam int LL = 40;   // line length in strobes
   localparam int FL = 20;   // frame length in lines
   localparam int HO = 8;
   localparam int HA = 24;
   localparam int VO = 3;
   localparam int VA = 12;
   localparam int LK = 4;
   localparam int ACT_PIX = HA * VA;

   localparam int K_LOCK  = 0;
   localparam int K_FS    = 1;
   localparam int K_PROBE = 2;

   logic       i_clk, i_rst, i_pix_stb, i_hs, i_vs;
   logic [9:0] o_x;
   logic [8:0] o_y;
   logic       o_active, o_locked, o_frame_start;
   logic [9:0] o_line_len;

   vga_sync_rx #(
      .LINE_LEN  (LL),
      .FRAME_LEN (FL),
      .H_ACT_OFS (HO),
      .H_ACT     (HA),
      .V_ACT_OFS (VO),
      .V_ACT     (VA),
      .LOCK_LINES(LK)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_pix_stb    (i_pix_stb),
      .i_hs         (i_hs),
      .i_vs         (i_vs),
      .o_x          (o_x),
      .o_y          (o_y),
      .o_active     (o_active),
      .o_locked     (o_locked),
      .o_frame_start(o_frame_start),
      .o_line_len   (o_line_len)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   typedef struct {
      int kind;
      int x;       // probe x, or expected active count for K_FS (-1 = skip)
      int y;
      int act;
      int locked;
      int len;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   probe_seq = 0;
   bit   mon_en = 1'b0;
   bit   done = 1'b0;
   bit   probe_en = 1'b0;
   int   vs_h = 2;

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic push(input int kind, input int x, input int y, input int act,
                       input int locked, input int len);
      exp_t e;
      e.kind = kind; e.x = x; e.y = y; e.act = act; e.locked = locked; e.len = len;
      q.push_back(e);
   endtask

   task automatic probe(input int x, input int y, input int act, input int locked,
                        input int len);
      push(K_PROBE, x, y, act, locked, len);
      probe_seq++;
   endtask

   // Called at posedge+1; leaves at posedge+1 four clocks later.
   task automatic pix(input logic hs, input logic vs);
      i_hs = hs;
      i_vs = vs;
      i_pix_stb = 1'b1;
      @(posedge i_clk);
      #1 i_pix_stb = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
   endtask

   function automatic logic hs_val(input int h);
      return (h >= 2 && h < 8) ? 1'b0 : 1'b1;
   endfunction

   function automatic logic vs_val(input int l, input int h);
      return ((l == 0 && h >= vs_h) || l == 1 || (l == 2 && h < vs_h)) ? 1'b0 : 1'b1;
   endfunction

   function automatic bit is_probe(input int l, input int h);
      return (l == 2 && h == 20) || (l == 3 && (h == 1 || h == 10 || h == 33)) ||
             (l == 14 && (h == 33 || h == 34)) || (l == 15 && h == 10);
   endfunction

   // Expected outputs of a locked receiver from generator coordinates:
   // hsync falls at h=2, so h_cnt trails h by 2 and the line index changes there.
   task automatic probe_model(input int l, input int h);
      int hc, v, ex, ey;
      bit hin, vin;
      hc  = (h >= 2) ? h - 2 : h + LL - 2;
      v   = (h >= 2) ? l : (l + FL - 1) % FL;
      hin = (hc >= HO) && (hc < HO + HA);
      vin = (v >= VO) && (v < VO + VA);
      ex  = hin ? hc - HO : 0;
      ey  = vin ? v - VO : 0;
      probe(ex, ey, int'(hin && vin), 1, LL);
   endtask

   task automatic line(input int l, input int len);
      for (int h = 0; h < len; h++) begin
         pix(hs_val(h), vs_val(l, h));
         if (probe_en && is_probe(l, h))
            probe_model(l, h);
      end
   endtask

   task automatic frame(input int nlines);
      for (int l = 0; l < nlines; l++)
         line(l, LL);
   endtask

   // ------------------------------------------------------------------
   // Stimulus sequence
   // ------------------------------------------------------------------
   initial begin
      i_rst = 1'b1; i_pix_stb = 1'b0; i_hs = 1'b1; i_vs = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;
      // strobes with hsync low while reset is held must not count
      pix(1'b0, 1'b1);
      pix(1'b0, 1'b0);
      i_rst = 1'b0;
      mon_en = 1'b1;
      probe(0, 0, 0, 0, 0);

      // acquire: first edge on line 3, good lines 4..7, lock on next vsync
      for (int l = 3; l < FL; l++) line(l, LL);

      // frame A: lock rises at its vsync, positions probed
      push(K_LOCK, 0, 0, 0, 1, LL);
      probe_en = 1'b1;
      frame(FL);

      // frame B: vsync falls two strobes before hsync (skip path)
      push(K_FS, ACT_PIX, 0, 0, 0, 0);
      vs_h = 0;
      frame(FL);

      // frame C: line 5 shortened to 30 strobes
      push(K_FS, ACT_PIX, 0, 0, 0, 0);
      vs_h = 2;
      probe_en = 1'b0;
      for (int l = 0; l < 5; l++) line(l, LL);
      line(5, 30);
      push(K_LOCK, 0, 0, 0, 0, 30);
      for (int l = 6; l < FL; l++) line(l, LL);

      // frame D: relock, then hsync missing after line 5
      push(K_LOCK, 0, 0, 0, 1, LL);
      for (int l = 0; l < 6; l++) line(l, LL);
      for (int k = 0; k < 17; k++) pix(1'b1, 1'b1);
      probe(0, 2, 0, 1, LL);              // h_cnt = LL+14, still locked
      push(K_LOCK, 0, 0, 0, 0, LL);
      pix(1'b1, 1'b1);                    // h_cnt = LL+15
      probe(0, 0, 0, 0, LL);
      for (int k = 0; k < 5; k++) pix(1'b1, 1'b1);
      for (int l = 6; l < FL; l++) line(l, LL);

      // frame E: relock, frame one line short
      push(K_LOCK, 0, 0, 0, 1, LL);
      frame(FL - 1);

      // frame F
`ifdef VGA_SYNC_RX_FRAME_CHECK_EN
      push(K_LOCK, 0, 0, 0, 0, LL);
`else
      push(K_FS, ACT_PIX, 0, 0, 0, 0);
`endif
      frame(FL);

      // frame G: reset mid-frame while locked
`ifdef VGA_SYNC_RX_FRAME_CHECK_EN
      push(K_LOCK, 0, 0, 0, 1, LL);
`else
      push(K_FS, ACT_PIX, 0, 0, 0, 0);
`endif
      for (int l = 0; l < 8; l++) line(l, LL);
      line(8, 20);
      push(K_LOCK, 0, 0, 0, 0, 0);
      i_rst = 1'b1;
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      probe(0, 0, 0, 0, 0);
      // good lines without a vsync must not bring lock back
      for (int l = 9; l < 15; l++) line(l, LL);

      repeat (4) @(posedge i_clk);
      done = 1'b1;
   end

   // ------------------------------------------------------------------
   // Monitor / scoreboard
   // ------------------------------------------------------------------
   int   probe_seen = 0;
   int   act_cnt = 0;
   int   cyc = 0;
   logic prev_locked = 1'b0;

   task automatic chk(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
      end
   endtask

   task automatic pop(input int kind);
      exp_t e;
      if (q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: got kind %0d expected nothing pending (t=%0t)",
                  kind, $time);
         return;
      end
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      case (kind)
         K_LOCK: begin
            chk("lock_state", int'(o_locked), e.locked);
            chk("lock_line_len", int'(o_line_len), e.len);
         end
         K_FS: begin
            if (e.x >= 0) chk("active_per_frame", act_cnt, e.x);
            act_cnt = 0;
         end
         default: begin
            chk("probe_x", int'(o_x), e.x);
            chk("probe_y", int'(o_y), e.y);
            chk("probe_active", int'(o_active), e.act);
            chk("probe_locked", int'(o_locked), e.locked);
            chk("probe_line_len", int'(o_line_len), e.len);
         end
      endcase
   endtask

   initial begin
      forever begin
         @(negedge i_clk);
         cyc++;
         if (mon_en) begin
            if (o_locked !== prev_locked) begin
               if (o_locked === 1'b1) act_cnt = 0;
               pop(K_LOCK);
            end
            if (o_frame_start === 1'b1) pop(K_FS);
            if (i_pix_stb && o_active === 1'b1) act_cnt++;
            if (probe_seq != probe_seen) begin
               probe_seen++;
               pop(K_PROBE);
            end
         end
         prev_locked = o_locked;
         if (done || cyc > 90000) begin
            if (!done) begin
               errors++;
               $display("FAIL timeout: got %0d cycles expected stimulus to finish", cyc);
            end
            chk("pending_events", q.size(), 0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
         end
      end
   end

endmodule
